// File: rtl/fir_tap_mac_if.sv
// Sample, SRAM read port and result bundle for the 10-tap FIR MAC.
// The slave side is the MAC; the master side is the sample source, the result sink and the SRAM.
interface fir_tap_mac_if #(
  parameter int IN_W   = 3,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16
);
  logic                     iEnSample;
  logic signed [IN_W-1:0]   iFirIn;
  logic                     oCsnRam;
  logic                     oWrnRam;
  logic        [3:0]        oAddrRam;
  logic signed [COEF_W-1:0] iRdDtRam;
  logic signed [OUT_W-1:0]  oFirOut;
  logic                     oFirOutValid;
  logic                     oBusy;
  logic                     oOverrun;

  modport slave (
    input  iEnSample, iFirIn, iRdDtRam,
    output oCsnRam, oWrnRam, oAddrRam, oFirOut, oFirOutValid, oBusy, oOverrun
  );

  modport master (
    output iEnSample, iFirIn, iRdDtRam,
    input  oCsnRam, oWrnRam, oAddrRam, oFirOut, oFirOutValid, oBusy, oOverrun
  );
endinterface

// File: rtl/fir_tap_mac.sv
// 10-tap FIR multiply-accumulate that streams its coefficients from a read-only SRAM port.
// One result per accepted sample, 13 cycles per sample; samples arriving while busy are dropped.
module fir_tap_mac #(
  parameter int IN_W   = 3,
  parameter int COEF_W = 16,
  parameter int TAPS   = 10,
  parameter int ACC_W  = 23,
  parameter int OUT_W  = 16
) (
  input  logic           iClk12M,
  input  logic           iRst,
  fir_tap_mac_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  state_t                          state;
  logic signed [IN_W-1:0]          rTap [TAPS];
  logic signed [ACC_W-1:0]         acc;
  logic        [3:0]               cnt;
  logic        [3:0]               rIdx;
  logic                            rRdVld;
  logic signed [IN_W+COEF_W-1:0]   product;
  logic signed [OUT_W-1:0]         satOut;

  // rIdx trails the address by one cycle so it lines up with the SRAM's registered read data.
  assign product = bus.iRdDtRam * rTap[rIdx];

  always_comb begin
    satOut = acc[OUT_W-1:0];
    if (acc > SAT_MAX) begin
      satOut = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      satOut = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state            <= IDLE;
      rTap             <= '{default: '0};
      acc              <= '0;
      cnt              <= '0;
      rIdx             <= '0;
      rRdVld           <= 1'b0;
      bus.oCsnRam      <= 1'b1;
      bus.oWrnRam      <= 1'b1;
      bus.oAddrRam     <= '0;
      bus.oFirOut      <= '0;
      bus.oFirOutValid <= 1'b0;
      bus.oBusy        <= 1'b0;
      bus.oOverrun     <= 1'b0;
    end else begin
      rRdVld           <= (state == RUN);
      rIdx             <= cnt;
      bus.oWrnRam      <= 1'b1;
      bus.oFirOutValid <= 1'b0;

      if (rRdVld) begin
        acc <= acc + ACC_W'(product);
      end

      if (bus.iEnSample && (state != IDLE)) begin
        bus.oOverrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.iEnSample) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              rTap[k] <= rTap[k-1];
            end
            rTap[0]      <= bus.iFirIn;
            acc          <= '0;
            cnt          <= '0;
            bus.oCsnRam  <= 1'b0;
            bus.oAddrRam <= '0;
            bus.oBusy    <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST_TAP) begin
            bus.oCsnRam  <= 1'b1;
            bus.oAddrRam <= '0;
            state        <= DRAIN;
          end else begin
            cnt          <= cnt + 4'd1;
            bus.oAddrRam <= cnt + 4'd1;
          end
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          bus.oFirOut      <= satOut;
          bus.oFirOutValid <= 1'b1;
          bus.oBusy        <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed bench for fir_tap_mac with a registered coefficient SRAM model.
// Expected results are hand-computed sums of h[k]*x[n-k] with 16-bit saturation.
module tb_fir_tap_mac;

  logic iClk12M;
  logic iRst;
  int   nVec;
  int   nMis;

  logic signed [15:0] coef [16];

  fir_tap_mac_if bus ();

  fir_tap_mac dut (
    .iClk12M (iClk12M),
    .iRst    (iRst),
    .bus     (bus)
  );

  initial iClk12M = 1'b0;
  always #42 iClk12M = ~iClk12M;

  // Registered single-port SRAM, read-only from the MAC's side; outputs 0 while deselected.
  always @(posedge iClk12M) begin
    bus.iRdDtRam <= bus.oCsnRam ? 16'sd0 : coef[bus.oAddrRam];
  end

  task automatic doReset();
    @(negedge iClk12M);
    iRst = 1'b1;
    @(negedge iClk12M);
    @(negedge iClk12M);
    iRst = 1'b0;
  endtask

  task automatic loadRamp(input logic signed [15:0] h0);
    for (int k = 0; k < 16; k++) coef[k] = 16'(k + 1);
    coef[0] = h0;
  endtask

  task automatic loadFlat(input logic signed [15:0] h);
    for (int k = 0; k < 16; k++) coef[k] = h;
  endtask

  task automatic runSample(input logic signed [2:0] x, output logic signed [15:0] y, output bit got);
    @(negedge iClk12M);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = x;
    @(negedge iClk12M);
    bus.iEnSample = 1'b0;
    got = 1'b0;
    y   = '0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge iClk12M);
      if (bus.oFirOutValid) begin
        got = 1'b1;
        y   = bus.oFirOut;
      end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    @(negedge iClk12M);
    @(negedge iClk12M);
    iRst = 1'b0;
    @(negedge iClk12M);
    nVec += 7;
    if (bus.oCsnRam !== 1'b1) begin nMis++; $display("[TB] FAIL reset_csn: got %b expected 1", bus.oCsnRam); end
    if (bus.oWrnRam !== 1'b1) begin nMis++; $display("[TB] FAIL reset_wrn: got %b expected 1", bus.oWrnRam); end
    if (bus.oAddrRam !== 4'd0) begin nMis++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.oAddrRam); end
    if (bus.oFirOut !== 16'sd0) begin nMis++; $display("[TB] FAIL reset_out: got %0d expected 0", bus.oFirOut); end
    if (bus.oFirOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.oFirOutValid); end
    if (bus.oBusy !== 1'b0) begin nMis++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.oBusy); end
    if (bus.oOverrun !== 1'b0) begin nMis++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.oOverrun); end
  endtask

  task automatic test_protocol();
    logic expCsn;
    logic expValid;
    doReset();
    loadRamp(16'sd1);
    @(negedge iClk12M);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = 3'sd1;
    for (int i = 0; i < 16; i++) begin
      @(negedge iClk12M);
      bus.iEnSample = 1'b0;
      expCsn   = (i > 9);
      expValid = (i == 12);
      nVec += 3;
      if (bus.oCsnRam !== expCsn) begin nMis++; $display("[TB] FAIL proto_csn cycle %0d: got %b expected %b", i, bus.oCsnRam, expCsn); end
      if (bus.oWrnRam !== 1'b1) begin nMis++; $display("[TB] FAIL proto_wrn cycle %0d: got %b expected 1", i, bus.oWrnRam); end
      if (bus.oFirOutValid !== expValid) begin nMis++; $display("[TB] FAIL proto_valid cycle %0d: got %b expected %b", i, bus.oFirOutValid, expValid); end
      if (i <= 9) begin
        nVec++;
        if (bus.oAddrRam !== 4'(i)) begin nMis++; $display("[TB] FAIL proto_addr cycle %0d: got %0d expected %0d", i, bus.oAddrRam, i); end
      end
      if (i <= 11 || i >= 13) begin
        nVec++;
        if (bus.oBusy !== (i <= 11)) begin nMis++; $display("[TB] FAIL proto_busy cycle %0d: got %b expected %b", i, bus.oBusy, (i <= 11)); end
      end
      if (i == 12) begin
        nVec++;
        if (bus.oFirOut !== 16'sd1) begin nMis++; $display("[TB] FAIL proto_result: got %0d expected 1", bus.oFirOut); end
      end
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] y;
    logic signed [15:0] exp;
    bit got;
    doReset();
    loadRamp(16'sd1);
    for (int n = 0; n < 11; n++) begin
      runSample((n == 0) ? 3'sd1 : 3'sd0, y, got);
      exp = (n < 10) ? 16'(n + 1) : 16'sd0;
      nVec++;
      if (!got || y !== exp) begin nMis++; $display("[TB] FAIL impulse n=%0d: got %0d (valid seen %0d) expected %0d", n, y, got, exp); end
    end
  endtask

  task automatic test_arith();
    logic signed [15:0] y;
    bit got;
    doReset();
    loadFlat(16'sd1);
    for (int n = 0; n < 10; n++) begin
      runSample(3'sd3, y, got);
      nVec++;
      if (!got || y !== 16'(3 * (n + 1))) begin nMis++; $display("[TB] FAIL arith_ones n=%0d: got %0d expected %0d", n, y, 3 * (n + 1)); end
    end
    doReset();
    loadFlat(16'sh7FFF);
    for (int n = 0; n < 10; n++) runSample(3'sd3, y, got);
    nVec++;
    if (!got || y !== 16'sd32767) begin nMis++; $display("[TB] FAIL sat_high: got %0d expected 32767", y); end
    doReset();
    runSample(-3'sd4, y, got);
    nVec++;
    if (!got || y !== -16'sd32768) begin nMis++; $display("[TB] FAIL sat_low: got %0d expected -32768", y); end
  endtask

  task automatic test_overrun();
    logic signed [15:0] y;
    bit got;
    doReset();
    loadRamp(16'sd1);
    @(negedge iClk12M);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = 3'sd1;
    @(negedge iClk12M);
    bus.iEnSample = 1'b0;
    repeat (4) @(negedge iClk12M);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = 3'sd3;
    @(negedge iClk12M);
    bus.iEnSample = 1'b0;
    got = 1'b0;
    y   = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge iClk12M);
      if (bus.oFirOutValid) begin got = 1'b1; y = bus.oFirOut; end
    end
    nVec += 2;
    if (!got || y !== 16'sd1) begin nMis++; $display("[TB] FAIL overrun_result: got %0d expected 1", y); end
    if (bus.oOverrun !== 1'b1) begin nMis++; $display("[TB] FAIL overrun_flag: got %b expected 1", bus.oOverrun); end
    runSample(3'sd0, y, got);
    nVec += 2;
    if (!got || y !== 16'sd2) begin nMis++; $display("[TB] FAIL overrun_history: got %0d expected 2", y); end
    if (bus.oOverrun !== 1'b1) begin nMis++; $display("[TB] FAIL overrun_sticky: got %b expected 1", bus.oOverrun); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] y;
    bit got;
    int validSeen;
    doReset();
    loadRamp(16'sd5);
    runSample(3'sd1, y, got);
    nVec++;
    if (!got || y !== 16'sd5) begin nMis++; $display("[TB] FAIL midrst_prime: got %0d expected 5", y); end
    @(negedge iClk12M);
    bus.iEnSample = 1'b1;
    bus.iFirIn    = 3'sd3;
    validSeen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge iClk12M);
      bus.iEnSample = 1'b0;
      if (i == 5) iRst = 1'b1;
      if (i == 7) begin
        iRst = 1'b0;
        nVec += 3;
        if (bus.oCsnRam !== 1'b1) begin nMis++; $display("[TB] FAIL midrst_csn: got %b expected 1", bus.oCsnRam); end
        if (bus.oBusy !== 1'b0) begin nMis++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.oBusy); end
        if (bus.oAddrRam !== 4'd0) begin nMis++; $display("[TB] FAIL midrst_addr: got %0d expected 0", bus.oAddrRam); end
      end
      if (bus.oFirOutValid) validSeen++;
    end
    nVec++;
    if (validSeen !== 0) begin nMis++; $display("[TB] FAIL midrst_novalid: got %0d strobes expected 0", validSeen); end
    runSample(3'sd2, y, got);
    nVec++;
    if (!got || y !== 16'sd10) begin nMis++; $display("[TB] FAIL midrst_result: got %0d expected 10", y); end
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    iRst = 1'b1;
    bus.iEnSample = 1'b0;
    bus.iFirIn    = '0;
    loadFlat(16'sd0);
    test_reset();
    test_protocol();
    test_impulse();
    test_arith();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/fir_tap_mac.md
Name: fir_tap_mac

Overview:
- Downstream consumer of the 10x16 single-port coefficient SRAM in the FIR datapath.
- For each accepted input sample, it shifts the sample into a 10-entry delay line.
- It then reads coefficients h[0..9] from the SRAM in sequence and multiply-accumulates y[n] = sum h[k]*x[n-k].
- It emits one saturated, signed result per sample with a one-cycle valid strobe.

Parameters:
- IN_W, 3, signed input sample width
- COEF_W, 16, signed coefficient width (matches SRAM data width)
- TAPS, 10, number of taps (= SRAM depth)
- ACC_W, 23, accumulator width (IN_W+COEF_W+4)
- OUT_W, 16, signed output width after saturation

Ports:
- iClk12M  in  1  system clock, 12 MHz
- iRst  in  1  synchronous, active-high reset
- iEnSample  in  1  input sample strobe, one cycle
- iFirIn  in  IN_W  signed input sample, valid with iEnSample
- oCsnRam  out  1  SRAM chip select, active low
- oWrnRam  out  1  SRAM write enable, active low; held at 1 (read-only user)
- oAddrRam  out  4  SRAM coefficient address
- iRdDtRam  in  COEF_W  SRAM read data; registered, 1-cycle latency; reads 0 while oCsnRam=1
- oFirOut  out  OUT_W  saturated filter result
- oFirOutValid  out  1  result strobe, one cycle
- oBusy  out  1  high whenever state != IDLE
- oOverrun  out  1  sticky; set when a sample is dropped; cleared only by iRst

Behaviour:
Reset (iRst=1 at a clock edge, any state, including mid-operation):
- State -> IDLE.
- Delay line, accumulator, counters -> 0.
- oCsnRam=1, oWrnRam=1, oAddrRam=0, oFirOut=0, oFirOutValid=0, oBusy=0, oOverrun=0.

FSM states: IDLE, RUN, DRAIN, DONE. Edge numbering: E0 is the edge that accepts a sample.
- IDLE:
  - If iEnSample=1 at E0: rTap[0]<=iFirIn, rTap[k]<=rTap[k-1] for k=1..9; acc<=0; cnt<=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - oCsnRam=0, oAddrRam=cnt. cnt increments each edge.
  - At the edge where cnt==TAPS-1 (E10), go to DRAIN.
  - Addresses 0..9 are driven between E0 and E10.
- DRAIN: oCsnRam=1, oAddrRam=0. Go to DONE.
- DONE: at E12, oFirOut<=sat(acc), oFirOutValid<=1, go to IDLE.
- oFirOutValid is high for exactly the single cycle after E12; it is 0 in all other cycles.

Read pipeline:
- rRdVld and rIdx register (state==RUN) and cnt each edge.
- Data for address k is on iRdDtRam after E(k+1).
- At E(k+2), while rRdVld=1: acc <= acc + signed(iRdDtRam)*signed(rTap[rIdx]).
- The final accumulation (k=9) occurs at E11.

Arithmetic:
- All operands are signed. The product is sign-extended to ACC_W; the accumulator does not wrap.
- sat(): clamp acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-32768, 32767].

Latency and throughput:
- Sample at E0 -> result valid after E12.
- Minimum sample spacing is 13 cycles; oBusy=1 from E0 through E12.

Overrun:
- iEnSample=1 while state != IDLE: the sample is dropped, the delay line is unchanged, and oOverrun<=1.
- The in-flight computation is unaffected.

Other rules:
- oWrnRam is never 0. The coefficient writer upstream owns the SRAM only while oBusy=0 (external mux).
- The delay line retains history across samples until reset.

Test Plan:
- Reset: assert iRst 2 cycles, including mid-RUN.
  -> All outputs hold reset values; oCsnRam=1; no oFirOutValid until the next accepted sample.
- Impulse with h[k]=k+1: feed x=1 then nine x=0, spaced 13 cycles.
  -> oFirOut sequence 1,2,...,10; an 11th sample x=0 gives 0.
- Protocol/latency: one sample at E0.
  -> oCsnRam low exactly 10 cycles; oAddrRam 0..9 in order; oWrnRam always 1; oFirOutValid high only in the cycle after E12.
- Arithmetic and saturation:
  - h all 1, ten samples x=3 -> last output 30.
  - h all 16'h7FFF, x=3 ten times -> 32767 (saturated high).
  - h all 16'h7FFF, fresh reset, x=-4 -> -131068 clamps to -32768.
- Overrun: sample at E0, second iEnSample at E5.
  -> Result unchanged from the single-sample case; oOverrun=1 and stays 1; the next legal sample sees a delay line without the dropped value.
- Reset mid-operation: iRst at E6, then a new sample x=2 with h[0]=5.
  -> No valid from the aborted run; new result = 10 (delay line cleared).
